// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I field requests into instruction words and writes them to consecutive memory words
module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        kind_i,
  input  logic [6:0]        funct7_i,
  input  logic [2:0]        funct3_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [11:0]       imm_i,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [31:0]       mem_data_o,
  input  logic              mem_ack_i,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              err_o
);
  localparam logic [1:0] IDLE = 2'd0, WRITE = 2'd1, FULL = 2'd2;
  logic [1:0] state;
  logic [ADDR_W-1:0] idx;
  logic [31:0] enc;
  logic legal;
  always_comb begin
    legal = kind_i <= 3'd4;
    // imm_i carries offset[12:1] for branches, so offset bit k sits at imm_i[k-1]
    enc = kind_i == 3'd0 ? {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, 7'b0110011} :
          kind_i == 3'd1 ? {imm_i, rs1_i, funct3_i, rd_i, 7'b0010011} :
          kind_i == 3'd2 ? {imm_i, rs1_i, funct3_i, rd_i, 7'b0000011} :
          kind_i == 3'd3 ? {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], 7'b0100011} :
                           {imm_i[11], imm_i[9:4], rs2_i, rs1_i, funct3_i, imm_i[3:0], imm_i[10], 7'b1100011};
  end
  assign req_ready_o = (state == IDLE) & ~rst_i;
  assign full_o = state == FULL;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      idx        <= '0;
      count_o    <= '0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= BASE_ADDR;
      mem_data_o <= '0;
      err_o      <= 1'b0;
    end else if (state == IDLE) begin
      if (req_valid_i && legal) begin
        mem_data_o <= enc;
        mem_addr_o <= BASE_ADDR + {{(30-ADDR_W){1'b0}}, idx, 2'b00};
        mem_we_o   <= 1'b1;
        state      <= WRITE;
      end else if (req_valid_i) begin
        err_o <= 1'b1;
      end
    end else if (state == WRITE && mem_ack_i) begin
      mem_we_o <= 1'b0;
      count_o  <= count_o + 1'b1;
      idx      <= idx + 1'b1;
      state    <= &idx ? FULL : IDLE;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors for the encoder with a 4-word memory (ADDR_W=2)
module tb_instr_encoder;
  logic clk = 0, rst = 1, req_valid = 0, req_ready, mem_we, mem_ack = 0, full, err;
  logic [2:0] kind = 0, funct3 = 0;
  logic [6:0] funct7 = 0;
  logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
  logic [11:0] imm = 0;
  logic [31:0] mem_addr, mem_data;
  logic [2:0] count;
  int n = 0, errs = 0;

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(32'h0)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .kind_i(kind), .funct7_i(funct7), .funct3_i(funct3), .rd_i(rd), .rs1_i(rs1),
    .rs2_i(rs2), .imm_i(imm), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_data_o(mem_data), .mem_ack_i(mem_ack), .count_o(count), .full_o(full), .err_o(err)
  );

  always #5 clk = ~clk;

  task step;
    @(posedge clk);
    #1;
  endtask

  task set_req(input logic [2:0] k, input logic [6:0] f7, input logic [2:0] f3,
               input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2, input logic [11:0] im);
    kind = k; funct7 = f7; funct3 = f3; rd = d; rs1 = s1; rs2 = s2; imm = im; req_valid = 1;
  endtask

  task do_reset;
    rst = 1; req_valid = 0; mem_ack = 0;
    step;
    step;
    rst = 0;
    #1;
  endtask

  task test_reset;
    rst = 1;
    step;
    step;
    n++; if (req_ready !== 1'b0) begin errs++; $display("FAIL rst_ready got %b want 0", req_ready); end
    n++; if (mem_we !== 1'b0) begin errs++; $display("FAIL rst_we got %b want 0", mem_we); end
    n++; if (mem_addr !== 32'h0) begin errs++; $display("FAIL rst_addr got %h want 0", mem_addr); end
    n++; if (mem_data !== 32'h0) begin errs++; $display("FAIL rst_data got %h want 0", mem_data); end
    n++; if ({count, full, err} !== 5'b0) begin errs++; $display("FAIL rst_cnt_full_err got %b want 0", {count, full, err}); end
    rst = 0;
    #1;
    n++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rst_release_ready got %b want 1", req_ready); end
  endtask

  task test_addi;
    set_req(3'd1, 7'd0, 3'd0, 5'd1, 5'd0, 5'd0, 12'd5);
    step;
    req_valid = 0;
    n++; if (mem_we !== 1'b1 || req_ready !== 1'b0) begin errs++; $display("FAIL addi_we_ready got %b%b want 10", mem_we, req_ready); end
    n++; if (mem_data !== 32'h00500093) begin errs++; $display("FAIL addi_data got %h want 00500093", mem_data); end
    n++; if (mem_addr !== 32'h0) begin errs++; $display("FAIL addi_addr got %h want 0", mem_addr); end
    n++; if (count !== 3'd0) begin errs++; $display("FAIL addi_cnt_pre got %0d want 0", count); end
    mem_ack = 1;
    step;
    mem_ack = 0;
    n++; if (count !== 3'd1) begin errs++; $display("FAIL addi_cnt got %0d want 1", count); end
    n++; if (req_ready !== 1'b1 || mem_we !== 1'b0) begin errs++; $display("FAIL addi_done got ready=%b we=%b want 1 0", req_ready, mem_we); end
  endtask

  task test_back_to_back;
    do_reset;
    set_req(3'd0, 7'd0, 3'd0, 5'd3, 5'd1, 5'd2, 12'd0);
    step;
    set_req(3'd2, 7'd0, 3'd2, 5'd4, 5'd1, 5'd0, 12'd4);
    n++; if (mem_data !== 32'h002081B3 || mem_addr !== 32'h0) begin errs++; $display("FAIL b2b_add got %h@%h want 002081b3@0", mem_data, mem_addr); end
    mem_ack = 1;
    step;
    n++; if (count !== 3'd1 || req_ready !== 1'b1) begin errs++; $display("FAIL b2b_mid got cnt=%0d ready=%b want 1 1", count, req_ready); end
    step;
    n++; if (mem_data !== 32'h0040A203 || mem_addr !== 32'h4 || mem_we !== 1'b1) begin errs++; $display("FAIL b2b_lw got %h@%h we=%b want 0040a203@4 1", mem_data, mem_addr, mem_we); end
    n++; if (count !== 3'd1) begin errs++; $display("FAIL b2b_idle_ack got cnt=%0d want 1", count); end
    req_valid = 0;
    step;
    mem_ack = 0;
    n++; if (count !== 3'd2 || mem_we !== 1'b0) begin errs++; $display("FAIL b2b_end got cnt=%0d we=%b want 2 0", count, mem_we); end
  endtask

  task test_stall;
    do_reset;
    set_req(3'd3, 7'd0, 3'd2, 5'd0, 5'd1, 5'd2, 12'd8);
    step;
    req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      n++; if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_data !== 32'h0020A423 || req_ready !== 1'b0 || count !== 3'd0)
        begin errs++; $display("FAIL stall_c%0d got we=%b %h@%h ready=%b cnt=%0d want 1 0020a423@0 0 0", i, mem_we, mem_data, mem_addr, req_ready, count); end
      mem_ack = (i == 3);
      step;
    end
    mem_ack = 0;
    n++; if (count !== 3'd1 || mem_we !== 1'b0) begin errs++; $display("FAIL stall_end got cnt=%0d we=%b want 1 0", count, mem_we); end
  endtask

  task test_branch_illegal;
    set_req(3'd4, 7'd0, 3'd0, 5'd0, 5'd1, 5'd2, 12'd4);
    step;
    req_valid = 0;
    n++; if (mem_data !== 32'h00208463 || mem_addr !== 32'h4) begin errs++; $display("FAIL beq got %h@%h want 00208463@4", mem_data, mem_addr); end
    mem_ack = 1;
    step;
    mem_ack = 0;
    set_req(3'd6, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 12'd0);
    step;
    req_valid = 0;
    n++; if (err !== 1'b1 || req_ready !== 1'b1 || count !== 3'd2 || mem_we !== 1'b0)
      begin errs++; $display("FAIL illegal got err=%b ready=%b cnt=%0d we=%b want 1 1 2 0", err, req_ready, count, mem_we); end
    step;
    step;
    n++; if (err !== 1'b1 || mem_we !== 1'b0) begin errs++; $display("FAIL err_sticky got err=%b we=%b want 1 0", err, mem_we); end
  endtask

  task test_full;
    logic [2:0] k [4] = '{3'd0, 3'd1, 3'd3, 3'd4};
    logic [6:0] f7 [4] = '{7'h20, 7'h0, 7'h0, 7'h0};
    logic [2:0] f3 [4] = '{3'd0, 3'd5, 3'd2, 3'd0};
    logic [4:0] d [4] = '{5'd1, 5'd5, 5'd0, 5'd0};
    logic [4:0] s1 [4] = '{5'd2, 5'd6, 5'd6, 5'd0};
    logic [4:0] s2 [4] = '{5'd3, 5'd0, 5'd5, 5'd0};
    logic [11:0] im [4] = '{12'h0, 12'h403, 12'hFF4, 12'hFFE};
    logic [31:0] exp [4] = '{32'h403100B3, 32'h40335293, 32'hFE532A23, 32'hFE000EE3};
    do_reset;
    for (int i = 0; i < 4; i++) begin
      set_req(k[i], f7[i], f3[i], d[i], s1[i], s2[i], im[i]);
      step;
      req_valid = 0;
      n++; if (mem_data !== exp[i] || mem_addr !== 32'(i * 4)) begin errs++; $display("FAIL full_w%0d got %h@%h want %h@%h", i, mem_data, mem_addr, exp[i], i * 4); end
      mem_ack = 1;
      step;
      mem_ack = 0;
    end
    n++; if (full !== 1'b1 || count !== 3'd4 || req_ready !== 1'b0 || mem_we !== 1'b0)
      begin errs++; $display("FAIL full got full=%b cnt=%0d ready=%b we=%b want 1 4 0 0", full, count, req_ready, mem_we); end
    set_req(3'd1, 7'd0, 3'd0, 5'd1, 5'd0, 5'd0, 12'd5);
    mem_ack = 1;
    for (int i = 0; i < 3; i++) begin
      step;
      n++; if (mem_we !== 1'b0 || req_ready !== 1'b0 || count !== 3'd4 || full !== 1'b1)
        begin errs++; $display("FAIL full_hold%0d got we=%b ready=%b cnt=%0d full=%b want 0 0 4 1", i, mem_we, req_ready, count, full); end
    end
    req_valid = 0;
    mem_ack = 0;
  endtask

  task test_reset_in_write;
    do_reset;
    set_req(3'd1, 7'd0, 3'd0, 5'd1, 5'd0, 5'd0, 12'd5);
    step;
    mem_ack = 1;
    step;
    mem_ack = 0;
    step;
    n++; if (mem_we !== 1'b1 || mem_addr !== 32'h4) begin errs++; $display("FAIL rw_pending got we=%b addr=%h want 1 4", mem_we, mem_addr); end
    rst = 1;
    mem_ack = 1;
    step;
    n++; if (mem_we !== 1'b0 || count !== 3'd0 || req_ready !== 1'b0) begin errs++; $display("FAIL rw_reset got we=%b cnt=%0d ready=%b want 0 0 0", mem_we, count, req_ready); end
    rst = 0;
    mem_ack = 0;
    step;
    req_valid = 0;
    n++; if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_data !== 32'h00500093) begin errs++; $display("FAIL rw_next got we=%b %h@%h want 1 00500093@0", mem_we, mem_data, mem_addr); end
    mem_ack = 1;
    step;
    mem_ack = 0;
    n++; if (count !== 3'd1) begin errs++; $display("FAIL rw_cnt got %0d want 1", count); end
  endtask

  initial begin
    test_reset;
    test_addi;
    test_back_to_back;
    test_stall;
    test_branch_illegal;
    test_full;
    test_reset_in_write;
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
